// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/debug arbiter for a single-port data memory
module data_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_stall,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_rvalid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_CPU = 2'd1,
        ACC_DBG = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic       cpu_gnt;
    logic       dbg_gnt;
    logic       dbg_forced;

    // Grant decision: CPU has priority unless debug has starved for MAX_WAIT cycles
    always_comb begin
        dbg_forced  = i_dbg_req && (wait_cnt == MAX_WAIT_C);
        cpu_gnt     = !i_reset && i_cpu_req && !dbg_forced;
        dbg_gnt     = !i_reset && i_dbg_req && (!i_cpu_req || dbg_forced);
        o_cpu_gnt   = cpu_gnt;
        o_dbg_gnt   = dbg_gnt;
        o_cpu_stall = !i_reset && i_cpu_req && !cpu_gnt;
    end

    // Access-owner state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the cycle after a grant is the winner's access cycle
    always_comb begin
        state_d = IDLE;
        if (cpu_gnt) begin
            state_d = ACC_CPU;
        end else if (dbg_gnt) begin
            state_d = ACC_DBG;
        end
    end

    // Starvation counter for a pending, ungranted debug request
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt <= 8'd0;
        end else if (i_dbg_req && !dbg_gnt) begin
            if (wait_cnt != MAX_WAIT_C) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Memory command register: latch the winner's request on the granting edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_we    <= 1'b0;
        end else if (cpu_gnt) begin
            o_mem_addr  <= i_cpu_addr;
            o_mem_wdata <= i_cpu_wdata;
            o_mem_we    <= i_cpu_we;
        end else if (dbg_gnt) begin
            o_mem_addr  <= i_dbg_addr;
            o_mem_wdata <= i_dbg_wdata;
            o_mem_we    <= i_dbg_we;
        end else begin
            o_mem_we    <= 1'b0;
        end
    end

    // Read return: route memory data to the owner of the read access just finished
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cpu_rdata  <= '0;
            o_cpu_rvalid <= 1'b0;
            o_dbg_rdata  <= '0;
            o_dbg_rvalid <= 1'b0;
        end else begin
            o_cpu_rvalid <= 1'b0;
            o_dbg_rvalid <= 1'b0;
            if (state_q == ACC_CPU && !o_mem_we) begin
                o_cpu_rdata  <= i_mem_rdata;
                o_cpu_rvalid <= 1'b1;
            end else if (state_q == ACC_DBG && !o_mem_we) begin
                o_dbg_rdata  <= i_mem_rdata;
                o_dbg_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          o_cpu_gnt, o_cpu_stall, o_cpu_rvalid;
    logic          o_dbg_gnt, o_dbg_rvalid;
    logic [DW-1:0] o_cpu_rdata, o_dbg_rdata;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_mem_we;
    logic [DW-1:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(o_cpu_gnt), .o_cpu_stall(o_cpu_stall),
        .o_cpu_rdata(o_cpu_rdata), .o_cpu_rvalid(o_cpu_rvalid),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_gnt(o_dbg_gnt), .o_dbg_rdata(o_dbg_rdata), .o_dbg_rvalid(o_dbg_rvalid),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .i_mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory environment: single port, acts on the falling edge
    logic [DW-1:0] ram [1024];
    always @(negedge clk) begin
        if (!rst && o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
        mem_rdata <= ram[o_mem_addr];
    end

    // Reference model: grant rules, starvation count, scheduled accesses and read returns
    int            mw = 0;
    int            cyc = 0;
    bit            acc_v [4];
    bit            acc_dbg [4];
    bit            acc_we [4];
    logic [AW-1:0] acc_addr [4];
    logic [DW-1:0] acc_wdata [4];
    bit            rv_v [4];
    bit            rv_dbg [4];
    logic [DW-1:0] rv_data [4];
    logic [DW-1:0] mmem [1024];
    logic [DW-1:0] exp_cpu_rdata = '0;
    logic [DW-1:0] exp_dbg_rdata = '0;
    int            cpu_rv_cnt = 0;
    int            dbg_rv_cnt = 0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  <= DW'(i);
            mmem[i] = DW'(i);
        end
    end

    always @(negedge clk) begin : compare
        int s;
        int sn;
        bit mc;
        bit md;
        s  = cyc % 4;
        sn = (cyc + 1) % 4;
        if (rst) begin
            chk("rst_cpu_gnt", o_cpu_gnt, 0);
            chk("rst_dbg_gnt", o_dbg_gnt, 0);
            chk("rst_stall", o_cpu_stall, 0);
            chk("rst_mem_we", o_mem_we, 0);
            chk("rst_mem_addr", o_mem_addr, 0);
            chk("rst_mem_wdata", o_mem_wdata, 0);
            chk("rst_cpu_rdata", o_cpu_rdata, 0);
            chk("rst_dbg_rdata", o_dbg_rdata, 0);
            chk("rst_cpu_rvalid", o_cpu_rvalid, 0);
            chk("rst_dbg_rvalid", o_dbg_rvalid, 0);
            for (int k = 0; k < 4; k++) begin
                acc_v[k] = 1'b0;
                rv_v[k]  = 1'b0;
            end
            mw = 0;
            exp_cpu_rdata = '0;
            exp_dbg_rdata = '0;
        end else begin
            mc = cpu_req && !(dbg_req && mw == MW);
            md = dbg_req && !mc;
            chk("cpu_gnt", o_cpu_gnt, mc);
            chk("dbg_gnt", o_dbg_gnt, md);
            chk("cpu_stall", o_cpu_stall, cpu_req && !mc);
            if (acc_v[s]) begin
                chk("mem_we", o_mem_we, acc_we[s]);
                chk("mem_addr", o_mem_addr, acc_addr[s]);
                if (acc_we[s]) begin
                    chk("mem_wdata", o_mem_wdata, acc_wdata[s]);
                    mmem[acc_addr[s]] = acc_wdata[s];
                end else begin
                    rv_v[sn]    = 1'b1;
                    rv_dbg[sn]  = acc_dbg[s];
                    rv_data[sn] = mmem[acc_addr[s]];
                end
                acc_v[s] = 1'b0;
            end else begin
                chk("mem_we_idle", o_mem_we, 0);
            end
            if (rv_v[s]) begin
                if (rv_dbg[s]) exp_dbg_rdata = rv_data[s];
                else           exp_cpu_rdata = rv_data[s];
            end
            chk("cpu_rvalid", o_cpu_rvalid, rv_v[s] && !rv_dbg[s]);
            chk("dbg_rvalid", o_dbg_rvalid, rv_v[s] && rv_dbg[s]);
            chk("cpu_rdata", o_cpu_rdata, exp_cpu_rdata);
            chk("dbg_rdata", o_dbg_rdata, exp_dbg_rdata);
            rv_v[s] = 1'b0;
            if (mc || md) begin
                acc_v[sn]     = 1'b1;
                acc_dbg[sn]   = md;
                acc_we[sn]    = mc ? cpu_we : dbg_we;
                acc_addr[sn]  = mc ? cpu_addr : dbg_addr;
                acc_wdata[sn] = mc ? cpu_wdata : dbg_wdata;
            end
            mw = (dbg_req && !md) ? ((mw < MW) ? mw + 1 : MW) : 0;
        end
        if (o_cpu_rvalid) cpu_rv_cnt++;
        if (o_dbg_rvalid) dbg_rv_cnt++;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic set_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // Starve debug behind a continuous CPU stream; returns CPU wins and debug win index
    task automatic starve(output int ncpu, output int dbg_at);
        ncpu = 0;
        dbg_at = -1;
        for (int i = 0; i < 12 && dbg_at < 0; i++) begin
            @(negedge clk);
            if (o_cpu_gnt) ncpu++;
            if (o_dbg_gnt) begin
                dbg_at = i;
                chk("starve_stall", o_cpu_stall, 1);
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ncpu;
        int dbg_at;
        int ndbg;
        rst = 1;
        idle();
        repeat (3) step();
        rst = 0;

        // CPU read of 0x005, first grant right after reset
        set_cpu(0, 10'h005, '0);
        @(negedge clk); chk("t1_gnt", o_cpu_gnt, 1);
        step(); idle();
        @(negedge clk); chk("t1_addr", o_mem_addr, 10'h005); chk("t1_we", o_mem_we, 0);
        step();
        @(negedge clk); chk("t1_rvalid", o_cpu_rvalid, 1); chk("t1_rdata", o_cpu_rdata, 32'h5);
        step();
        @(negedge clk); chk("t1_rvalid_off", o_cpu_rvalid, 0);

        // CPU write then read-back of 0x010
        step();
        set_cpu(1, 10'h010, 32'hDEADBEEF);
        @(negedge clk); chk("t2_wgnt", o_cpu_gnt, 1);
        step();
        set_cpu(0, 10'h010, '0);
        @(negedge clk); chk("t2_we", o_mem_we, 1);
        step(); idle();
        @(negedge clk); chk("t2_we_off", o_mem_we, 0);
        step();
        @(negedge clk); chk("t2_rvalid", o_cpu_rvalid, 1); chk("t2_rdata", o_cpu_rdata, 32'hDEADBEEF);

        // Both requesting continuously: debug wins on the ninth cycle
        repeat (2) step();
        set_cpu(0, 10'h003, '0);
        set_dbg(0, 10'h004, '0);
        starve(ncpu, dbg_at);
        idle();
        chk("t3_cpu_wins", ncpu, 8);
        chk("t3_dbg_cycle", dbg_at, 8);
        set_cpu(0, 10'h003, '0);
        set_dbg(0, 10'h004, '0);
        @(negedge clk); chk("t3_cnt_cleared", o_cpu_gnt, 1);
        step(); idle();

        // Alternating back-to-back owners
        repeat (3) step();
        cpu_rv_cnt = 0;
        dbg_rv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i % 2 == 0) set_cpu(0, 10'h001, '0);
            else            set_dbg(0, 10'h002, '0);
            @(negedge clk);
            chk("t4_gnt", (i % 2 == 0) ? o_cpu_gnt : o_dbg_gnt, 1);
            step();
        end
        idle();
        repeat (3) step();
        @(negedge clk);
        chk("t4_cpu_rdata", o_cpu_rdata, 32'h1);
        chk("t4_dbg_rdata", o_dbg_rdata, 32'h2);
        chk("t4_cpu_pulses", cpu_rv_cnt, 3);
        chk("t4_dbg_pulses", dbg_rv_cnt, 3);

        // Reset in the access cycle of a CPU write
        step();
        set_cpu(1, 10'h3FF, 32'h12345678);
        @(negedge clk); chk("t5_gnt", o_cpu_gnt, 1);
        @(posedge clk);
        #1 idle();
        #1 rst = 1;
        #1;
        chk("t5_we_async", o_mem_we, 0);
        chk("t5_addr_async", o_mem_addr, 0);
        chk("t5_rdata_async", o_cpu_rdata, 0);
        step(); step();
        rst = 0;

        // Reset in the access cycle of a CPU read suppresses its rvalid
        set_cpu(0, 10'h001, '0);
        @(negedge clk);
        @(posedge clk);
        #1 idle();
        #1 rst = 1;
        step();
        rst = 0;
        @(negedge clk); chk("t5_no_rvalid", o_cpu_rvalid, 0);
        step();

        // The aborted write never reached memory
        set_cpu(0, 10'h3FF, '0);
        @(negedge clk);
        step(); idle();
        step();
        @(negedge clk); chk("t5_rb_rvalid", o_cpu_rvalid, 1); chk("t5_rb_rdata", o_cpu_rdata, 32'h3FF);

        // Debug request withdrawn while CPU holds the bus
        step();
        set_cpu(0, 10'h007, '0);
        set_dbg(0, 10'h008, '0);
        ndbg = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_dbg_gnt) ndbg++;
            step();
        end
        dbg_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (o_dbg_gnt) ndbg++;
            step();
        end
        chk("t6_no_dbg", ndbg, 0);
        set_dbg(0, 10'h008, '0);
        starve(ncpu, dbg_at);
        idle();
        chk("t6_cnt_restart", ncpu, 8);

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
